// File: rtl/gene_compact_fifo.sv
// Packs surviving genes from the deletion stage into a show-ahead FIFO.
// Tracks per-genome node/connection survivor counts and genome completion.
module gene_compact_fifo #(
  parameter int GENE_SZ = 64,
  parameter int ATTR_SZ = 8,
  parameter int DEPTH   = 16,
  parameter int PTR_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               setup,
  input  logic               state,
  input  logic [GENE_SZ-1:0] gene_in,
  input  logic               in_valid,
  input  logic               genome_end,
  output logic [GENE_SZ-1:0] gene_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ATTR_SZ-1:0] node_count,
  output logic [ATTR_SZ-1:0] conn_count,
  output logic               overflow,
  output logic               done
);

  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);
  localparam logic [ATTR_SZ-1:0] CNT_MAX = '1;

  logic [GENE_SZ-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     occ_q, occ_d;
  logic [ATTR_SZ-1:0] node_cnt_q, node_cnt_d;
  logic [ATTR_SZ-1:0] conn_cnt_q, conn_cnt_d;
  logic               ovf_q, ovf_d;
  logic               end_seen_q, end_seen_d;
  logic               done_q, done_d;
  logic               full, rd_en, wr_en;

  assign out_valid  = (occ_q != '0);
  assign full       = (occ_q == FULL_OCC);
  assign rd_en      = out_valid && out_ready;
  assign wr_en      = in_valid && (!full || rd_en);
  assign gene_out   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign node_count = node_cnt_q;
  assign conn_count = conn_cnt_q;
  assign overflow   = ovf_q;
  assign done       = done_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    node_cnt_d = node_cnt_q;
    conn_cnt_d = conn_cnt_q;
    ovf_d      = ovf_q;
    end_seen_d = end_seen_q || genome_end;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!state && node_cnt_q != CNT_MAX)
        node_cnt_d = node_cnt_q + ATTR_SZ'(1);
      if (state && conn_cnt_q != CNT_MAX)
        conn_cnt_d = conn_cnt_q + ATTR_SZ'(1);
    end
    if (in_valid && !wr_en)
      ovf_d = 1'b1;
    if (rd_en)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case (1'b1)
      wr_en && !rd_en: occ_d = occ_q + (PTR_W+1)'(1);
      rd_en && !wr_en: occ_d = occ_q - (PTR_W+1)'(1);
      default:         occ_d = occ_q;
    endcase
    // An entry written this edge keeps done low until it drains.
    done_d = end_seen_d && (occ_d == '0);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= gene_in;
  end

  always_ff @(posedge clk) begin
    if (rst || setup) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      node_cnt_q <= '0;
      conn_cnt_q <= '0;
      ovf_q      <= 1'b0;
      end_seen_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      node_cnt_q <= node_cnt_d;
      conn_cnt_q <= conn_cnt_d;
      ovf_q      <= ovf_d;
      end_seen_q <= end_seen_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_gene_compact_fifo.sv
// Bench for gene_compact_fifo: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_gene_compact_fifo;

  logic        clk = 1'b0;
  logic        rst, setup, state, in_valid, genome_end, out_ready;
  logic [63:0] gene_in, gene_out;
  logic        out_valid, overflow, done;
  logic [7:0]  node_count, conn_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  int  m_node, m_conn;
  bit  m_ovf, m_end, m_done;

  always #5 clk = ~clk;

  gene_compact_fifo dut (
    .clk(clk), .rst(rst), .setup(setup), .state(state),
    .gene_in(gene_in), .in_valid(in_valid), .genome_end(genome_end),
    .gene_out(gene_out), .out_valid(out_valid), .out_ready(out_ready),
    .node_count(node_count), .conn_count(conn_count),
    .overflow(overflow), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_node = 0;
    m_conn = 0;
    m_ovf  = 0;
    m_end  = 0;
    m_done = 0;
  endtask

  // Expected outputs follow from the model state left by the last edge.
  task automatic check_outs();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("gene_out", gene_out, q.size() != 0 ? q[0] : 64'h0);
    chk("node_count", 64'(node_count), 64'(m_node));
    chk("conn_count", 64'(conn_count), 64'(m_conn));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("done", 64'(done), 64'(m_done));
  endtask

  task automatic model_edge();
    bit rd, wr;
    if (rst || setup) begin
      model_clear();
      return;
    end
    rd = (q.size() != 0) && out_ready;
    wr = in_valid && (q.size() < 16 || rd);
    if (rd) void'(q.pop_front());
    if (wr) begin
      q.push_back(gene_in);
      if (!state) m_node = (m_node < 255) ? m_node + 1 : 255;
      else        m_conn = (m_conn < 255) ? m_conn + 1 : 255;
    end
    if (in_valid && !wr) m_ovf = 1;
    if (genome_end) m_end = 1;
    m_done = m_end && (q.size() == 0);
  endtask

  task automatic cyc(input bit v, input bit st, input bit rdy,
                     input bit gend = 0, input bit su = 0, input bit r = 0);
    in_valid   = v;
    state      = st;
    out_ready  = rdy;
    genome_end = gend;
    setup      = su;
    rst        = r;
    gene_in    = {$urandom, $urandom};
    @(negedge clk);
    check_outs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; setup = 0; state = 0; in_valid = 0;
    genome_end = 0; out_ready = 0; gene_in = '0;
    model_clear();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // node genes with bubbles, then connection genes
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1);
      cyc(0, 0, 1);
    end
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    repeat (4) cyc(0, 0, 1);
    chk("tp1_node", 64'(node_count), 64'd3);
    chk("tp1_conn", 64'(conn_count), 64'd2);
    // 17 writes into 16 entries, then drain
    cyc(0, 0, 0, 0, 1);
    repeat (17) cyc(1, 0, 0);
    chk("tp2_ovf", 64'(overflow), 64'd1);
    chk("tp2_node", 64'(node_count), 64'd16);
    repeat (18) cyc(0, 0, 1);
    // full with concurrent read and write across the wrap
    cyc(0, 0, 0, 0, 1);
    repeat (16) cyc(1, 0, 0);
    repeat (4) cyc(1, 1, 1);
    chk("tp3_ovf", 64'(overflow), 64'd0);
    chk("tp3_full", 64'(out_valid), 64'd1);
    repeat (18) cyc(0, 0, 1);
    // genome end with two buffered entries
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0);
    chk("tp4_done_early", 64'(done), 64'd0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("tp4_done", 64'(done), 64'd1);
    repeat (3) cyc(0, 0, 0);
    chk("tp4_hold", 64'(done), 64'd1);
    // setup with five buffered entries
    cyc(0, 0, 0, 0, 1);
    repeat (5) cyc(1, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("tp5_valid", 64'(out_valid), 64'd0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("tp5_new", 64'(out_valid), 64'd1);
    // saturation
    cyc(0, 0, 0, 0, 1);
    repeat (300) cyc(1, 0, 1);
    chk("tp6_node", 64'(node_count), 64'd255);
    chk("tp6_conn", 64'(conn_count), 64'd0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
          $urandom_range(0, 200) == 0, $urandom_range(0, 500) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
